// File: rtl/segment_display_pkg.sv
// Shared types and constants for the multi-digit seven-segment display:
// active-low glyph encodings and the converter FSM states.
package segment_display_pkg;

    typedef logic [6:0] seg_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;

    localparam seg_t GLYPH [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/multi_digit_segment_display_if.sv
// Load/ready request bus and display outputs of multi_digit_segment_display.
// The blink line exists only when SEGMENT_BLINK_EN is defined.
interface multi_digit_segment_display_if #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_WIDTH = 20
);
    logic [DATA_WIDTH-1:0]   value_in;
    logic                    load;
    logic                    blank_zeros;
`ifdef SEGMENT_BLINK_EN
    logic                    blink;
`endif
    logic                    ready;
    logic                    overflow;
    logic [7*NUM_DIGITS-1:0] segments_out;

    modport master (
        input  ready, overflow, segments_out,
        output value_in, load, blank_zeros
`ifdef SEGMENT_BLINK_EN
        , blink
`endif
    );

    modport slave (
        output ready, overflow, segments_out,
        input  value_in, load, blank_zeros
`ifdef SEGMENT_BLINK_EN
        , blink
`endif
    );
endinterface

// File: rtl/seven_segment_glyph.sv
// One digit decoder: BCD nibble plus blank flag to an active-low glyph.
// Codes 10-15 cannot come out of a correct conversion and show blank.
module seven_segment_glyph
    import segment_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output seg_t       seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!blank && bcd <= 4'd9) seg = GLYPH[bcd];
    end
endmodule

// File: rtl/multi_digit_segment_display.sv
// Binary-to-decimal seven-segment driver: sequential double-dabble with a
// double-buffered display frame. Optional blinking with SEGMENT_BLINK_EN.
module multi_digit_segment_display
    import segment_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_WIDTH = 20
`ifdef SEGMENT_BLINK_EN
    , parameter int BLINK_PERIOD = 25000000
`endif
) (
    input logic clock_50Mhz,
    input logic reset,
    multi_digit_segment_display_if.slave bus
);
    localparam int              BCD_W     = 4 * NUM_DIGITS;
    localparam int              CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [63:0]     MAX_VALUE = 64'(10 ** NUM_DIGITS) - 64'd1;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [BCD_W-1:0]        bcd_q, bcd_adj;
    logic                    blank_q, ovf_q;

    logic [BCD_W-1:0]        disp_bcd;
    logic                    disp_blank, disp_ovf, disp_valid;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [7*NUM_DIGITS-1:0] segs;
    logic                    hide;
    logic                    show;

    always_ff @(posedge clock_50Mhz) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.load) state_next = CONVERT;
            CONVERT: if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.ready = (state == IDLE);

    // Add-3 correction applied to every nibble before each shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            bit_cnt    <= '0;
            shift_q    <= '0;
            bcd_q      <= '0;
            blank_q    <= 1'b0;
            ovf_q      <= 1'b0;
            disp_bcd   <= '0;
            disp_blank <= 1'b0;
            disp_ovf   <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.load) begin
                    shift_q <= bus.value_in;
                    blank_q <= bus.blank_zeros;
                    ovf_q   <= 64'(bus.value_in) > MAX_VALUE;
                    bcd_q   <= '0;
                    bit_cnt <= '0;
                end
                CONVERT: begin
                    // Bits shifted past the top nibble are dropped; ovf_q covers them
                    bcd_q   <= (bcd_adj << 1) | BCD_W'(shift_q[DATA_WIDTH-1]);
                    shift_q <= shift_q << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                COMMIT: begin
                    disp_bcd   <= bcd_q;
                    disp_blank <= blank_q;
                    disp_ovf   <= ovf_q;
                    disp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Zero digits above the highest non-zero digit; digit 0 always shows
    always_comb begin
        logic seen_nz;
        seen_nz  = 1'b0;
        lz_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (disp_bcd[4*k +: 4] != 4'd0) seen_nz = 1'b1;
            lz_blank[k] = disp_blank && !seen_nz;
        end
    end

`ifdef SEGMENT_BLINK_EN
    localparam int BLK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    logic [BLK_W-1:0] blink_cnt;
    logic             phase;
    logic             blink_wrap;

    assign blink_wrap = (blink_cnt == BLK_W'(BLINK_PERIOD - 1));

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
            if (!bus.blink)      phase <= 1'b0;
            else if (blink_wrap) phase <= ~phase;
        end
    end

    // phase can only be set while blink was high, so it alone gates the frame
    assign hide = phase;
`else
    assign hide = 1'b0;
`endif

    assign show = disp_valid && !hide;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        seg_t glyph;
        seven_segment_glyph u_glyph (
            .bcd   (disp_bcd[4*k +: 4]),
            .blank (!show || lz_blank[k]),
            .seg   (glyph)
        );
        assign segs[7*k +: 7] = (show && disp_ovf) ? SEG_DASH : glyph;
    end

    assign bus.segments_out = segs;
    assign bus.overflow     = disp_ovf;

endmodule

// File: tb/tb_multi_digit_segment_display.sv
// Randomized bench for multi_digit_segment_display with a cycle-level
// decimal model plus directed literal frames.
module tb_multi_digit_segment_display;
    localparam int ND = 6;
    localparam int DW = 20;
    localparam int BP = 8;
    localparam longint unsigned MAXV = 999999;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_digit_segment_display_if #(.NUM_DIGITS(ND), .DATA_WIDTH(DW)) bus ();

    multi_digit_segment_display #(
        .NUM_DIGITS(ND), .DATA_WIDTH(DW)
`ifdef SEGMENT_BLINK_EN
        , .BLINK_PERIOD(BP)
`endif
    ) dut (
        .clock_50Mhz (clk),
        .reset       (reset),
        .bus         (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame from plain decimal arithmetic
    function automatic logic [7*ND-1:0] frame(input bit valid, input longint unsigned v,
                                              input bit bz, input bit hide);
        logic [7*ND-1:0] f;
        longint unsigned p = 1;
        for (int k = 0; k < ND; k++) begin
            if (!valid || hide)         f[7*k +: 7] = 7'h7F;
            else if (v > MAXV)          f[7*k +: 7] = 7'h3F;
            else if (bz && k > 0 && v < p) f[7*k +: 7] = 7'h7F;
            else                        f[7*k +: 7] = tab[int'((v / p) % 10)];
            p = p * 10;
        end
        return f;
    endfunction

    // Model: a frame is shown DW+1 edges after acceptance; busy blocks loads
    int              m_busy;
    bit              m_valid, m_bz, m_pbz, m_phase;
    longint unsigned m_val, m_pval;
    int              m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            m_busy  <= 0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_phase <= 1'b0;
        end else begin
            if (m_busy != 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_valid <= 1'b1;
                    m_val   <= m_pval;
                    m_bz    <= m_pbz;
                end
            end else if (bus.load) begin
                m_pval <= longint'(bus.value_in);
                m_pbz  <= bus.blank_zeros;
                m_busy <= DW + 1;
            end
            m_cnt <= (m_cnt == BP - 1) ? 0 : m_cnt + 1;
`ifdef SEGMENT_BLINK_EN
            if (!bus.blink)          m_phase <= 1'b0;
            else if (m_cnt == BP - 1) m_phase <= !m_phase;
`endif
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("segments", bus.segments_out, frame(m_valid, m_val, m_bz, m_phase));
            chk("ready", bus.ready, m_busy == 0);
            chk("overflow", bus.overflow, m_valid && (m_val > MAXV));
        end
    end

    task automatic start_load(input int unsigned v, input bit bz);
        bus.value_in    = DW'(v);
        bus.blank_zeros = bz;
        bus.load        = 1'b1;
        @(negedge clk);
        bus.load        = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (bus.ready !== 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("ready_timeout", cyc < 100, 1'b1);
    endtask

    int cyc;

    initial begin
        reset = 1'b1;
        bus.load = 1'b0;
        bus.value_in = '0;
        bus.blank_zeros = 1'b0;
`ifdef SEGMENT_BLINK_EN
        bus.blink = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checking = 1'b1;
        chk("reset_segs", bus.segments_out, {ND{7'h7F}});
        chk("reset_ready", bus.ready, 1'b1);
        chk("reset_ovf", bus.overflow, 1'b0);
        reset = 1'b0;

        start_load(123456, 1'b0);
        wait_ready(cyc);
        chk("ready_low_cycles", cyc, 21);
        chk("frame_123456", bus.segments_out,
            {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

        start_load(42, 1'b1);
        wait_ready(cyc);
        chk("frame_42_blank", bus.segments_out,
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});

        start_load(0, 1'b1);
        wait_ready(cyc);
        chk("frame_0_blank", bus.segments_out,
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        start_load(1000000, 1'b1);
        wait_ready(cyc);
        chk("frame_ovf", bus.segments_out, {ND{7'h3F}});
        chk("ovf_flag", bus.overflow, 1'b1);

        start_load(999999, 1'b0);
        wait_ready(cyc);
        chk("frame_999999", bus.segments_out, {ND{7'h10}});
        chk("ovf_clear", bus.overflow, 1'b0);

        // Load while busy is dropped
        start_load(5, 1'b0);
        repeat (2) @(negedge clk);
        start_load(7, 1'b0);
        wait_ready(cyc);
        chk("frame_5_not_7", bus.segments_out,
            {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12});

        // Reset mid-conversion blanks rather than restoring the old frame
        start_load(777, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_segs", bus.segments_out, {ND{7'h7F}});
        chk("abort_ready", bus.ready, 1'b1);

`ifdef SEGMENT_BLINK_EN
        start_load(123456, 1'b0);
        wait_ready(cyc);
        bus.blink = 1'b1;
        repeat (40) @(negedge clk);
        bus.blink = 1'b0;
        @(negedge clk);
        chk("blink_off_visible", bus.segments_out,
            {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
`endif

        for (int c = 0; c < 3000; c++) begin
            bus.load        = ($urandom_range(0, 3) == 0);
            bus.value_in    = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 999))
                                                          : DW'($urandom_range(0, 20'hFFFFF));
            bus.blank_zeros = $urandom_range(0, 1) == 1;
            reset           = ($urandom_range(0, 499) == 0);
`ifdef SEGMENT_BLINK_EN
            if ($urandom_range(0, 63) == 0) bus.blink = !bus.blink;
`endif
            @(negedge clk);
        end
        reset    = 1'b0;
        bus.load = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
